// File: rtl/mmp_iddmm_resp_if.sv
// Controller <-> Montgomery responder bus: operand/modulus word writes plus the task handshake.
interface mmp_iddmm_resp_if #(
  parameter int K      = 128,
  parameter int ADDR_W = 4
);
  logic [1:0]        wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_x;
  logic [K-1:0]      wr_y;
  logic              wr_m_ena;
  logic [K-1:0]      wr_m;
  logic [K-1:0]      wr_m1;
  logic              task_req;
  logic              task_grant;
  logic [K-1:0]      task_res;
  logic              task_end;

  // task_req is level: it starts a task from IDLE and acts as ready during result streaming.
  // task_grant is valid for task_res; one word moves on every cycle task_grant is high,
  // and a grant is issued only for a cycle whose preceding edge sampled task_req high.
  modport master (
    output wr_ena, wr_addr, wr_x, wr_y, wr_m_ena, wr_m, wr_m1, task_req,
    input  task_grant, task_res, task_end
  );

  modport slave (
    input  wr_ena, wr_addr, wr_x, wr_y, wr_m_ena, wr_m, wr_m1, task_req,
    output task_grant, task_res, task_end
  );
endinterface

// File: rtl/mmp_iddmm_resp.sv
// Word-serial CIOS Montgomery multiplier responder: res = X*Y*2^(-K*N) mod M, one K x K multiplier,
// result streamed low word first under task_grant.
module mmp_iddmm_resp #(
  parameter int K      = 128,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  mmp_iddmm_resp_if.slave bus,
  output logic [2:0]      dbg_state_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  J_LAST = CNT_W'(N);
  localparam logic [CNT_W-1:0]  I_LAST = CNT_W'(N - 1);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_XY, S_RED_Q, S_MUL_QM, S_SHIFT, S_SUB, S_OUT, S_END
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  i_q, j_q;
  logic [ADDR_W-1:0] w_q;
  logic [K-1:0]      c_q, q_q, m1_q;
  logic [K-1:0]      t_q [N+2];
  logic [K-1:0]      d_q [N];
  logic              borrow_q, sel_q, armed_q;
  logic              grant_q, end_q;
  logic [K-1:0]      res_q;

  logic [K-1:0] x_mem [N];
  logic [K-1:0] y_mem [N];
  logic [K-1:0] m_mem [N];

  logic [ADDR_W-1:0] j_idx, i_idx, fin_w;
  logic [K-1:0]      mul_a, mul_b, t_j, m_word, res_word;
  logic [2*K-1:0]    prod, mac;
  logic [K:0]        top_sum, diff;
  logic              sub_last, fin_sel, issue_en;

  assign j_idx = j_q[ADDR_W-1:0];
  assign i_idx = i_q[ADDR_W-1:0];
  assign t_j   = t_q[j_q];

  // Single shared multiplier: operands steered by phase.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_XY: begin mul_a = x_mem[j_idx]; mul_b = y_mem[i_idx]; end
      S_RED_Q:  begin mul_a = t_q[0];       mul_b = m1_q;         end
      S_MUL_QM: begin mul_a = q_q;          mul_b = m_mem[j_idx]; end
      default:  begin mul_a = '0;           mul_b = '0;           end
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign mac     = prod + {{K{1'b0}}, t_j} + {{K{1'b0}}, c_q};
  assign top_sum = {1'b0, t_q[N]} + {1'b0, c_q};

  // Final subtraction runs over N+1 words; M has no word N.
  assign m_word = (j_q == J_LAST) ? '0 : m_mem[j_idx];
  assign diff   = {1'b0, t_j} - {1'b0, m_word} - {{K{1'b0}}, borrow_q};

  // The last SUB cycle already knows the final borrow, so word 0 can be issued straight away.
  assign sub_last = (state_q == S_SUB) && (j_q == J_LAST);
  assign fin_sel  = sub_last ? diff[K] : sel_q;
  assign fin_w    = sub_last ? '0 : w_q;
  assign res_word = fin_sel ? t_q[{1'b0, fin_w}] : d_q[fin_w];
  assign issue_en = sub_last || (state_q == S_OUT);

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      if (bus.wr_ena[0]) x_mem[bus.wr_addr] <= bus.wr_x;
      if (bus.wr_ena[1]) y_mem[bus.wr_addr] <= bus.wr_y;
      if (bus.wr_m_ena)  m_mem[bus.wr_addr] <= bus.wr_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      w_q      <= '0;
      c_q      <= '0;
      q_q      <= '0;
      m1_q     <= '0;
      borrow_q <= 1'b0;
      sel_q    <= 1'b0;
      armed_q  <= 1'b1;
      grant_q  <= 1'b0;
      end_q    <= 1'b0;
      res_q    <= '0;
      for (int k = 0; k < N + 2; k++) t_q[k] <= '0;
      for (int k = 0; k < N; k++)     d_q[k] <= '0;
    end else begin
      end_q <= 1'b0;
      if (!bus.task_req) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.task_req && armed_q) begin
            state_q <= S_MUL_XY;
            i_q     <= '0;
            j_q     <= '0;
            c_q     <= '0;
            m1_q    <= bus.wr_m1;
            for (int k = 0; k < N + 2; k++) t_q[k] <= '0;
          end
        end
        S_MUL_XY: begin
          if (j_q == J_LAST) begin
            t_q[N]   <= top_sum[K-1:0];
            t_q[N+1] <= {{(K-1){1'b0}}, top_sum[K]};
            c_q      <= '0;
            j_q      <= '0;
            state_q  <= S_RED_Q;
          end else begin
            t_q[j_q] <= mac[K-1:0];
            c_q      <= mac[2*K-1:K];
            j_q      <= j_q + 1'b1;
          end
        end
        S_RED_Q: begin
          q_q     <= prod[K-1:0];
          state_q <= S_MUL_QM;
        end
        S_MUL_QM: begin
          if (j_q == J_LAST) begin
            t_q[N]   <= top_sum[K-1:0];
            t_q[N+1] <= t_q[N+1] + {{(K-1){1'b0}}, top_sum[K]};
            c_q      <= '0;
            j_q      <= '0;
            state_q  <= S_SHIFT;
          end else begin
            t_q[j_q] <= mac[K-1:0];
            c_q      <= mac[2*K-1:K];
            j_q      <= j_q + 1'b1;
          end
        end
        S_SHIFT: begin
          for (int k = 0; k <= N; k++) t_q[k] <= t_q[k+1];
          t_q[N+1] <= '0;
          i_q      <= i_q + 1'b1;
          j_q      <= '0;
          borrow_q <= 1'b0;
          state_q  <= (i_q == I_LAST) ? S_SUB : S_MUL_XY;
        end
        S_SUB: begin
          if (sub_last) begin
            sel_q <= diff[K];
          end else begin
            d_q[j_idx] <= diff[K-1:0];
            borrow_q   <= diff[K];
            j_q        <= j_q + 1'b1;
          end
        end
        S_END: begin
          grant_q <= 1'b0;
          end_q   <= 1'b1;
          armed_q <= !bus.task_req;
          state_q <= S_IDLE;
        end
        default: ;
      endcase

      // Result streaming; the state assignment here overrides the SUB branch on its last cycle.
      if (issue_en) begin
        if (bus.task_req) begin
          grant_q <= 1'b1;
          res_q   <= res_word;
          w_q     <= fin_w + 1'b1;
          state_q <= (fin_w == W_LAST) ? S_END : S_OUT;
        end else begin
          grant_q <= 1'b0;
          w_q     <= fin_w;
          state_q <= S_OUT;
        end
      end
    end
  end

  assign bus.task_grant = grant_q;
  assign bus.task_res   = res_q;
  assign bus.task_end   = end_q;
  assign dbg_state_o    = state_q;

endmodule
